// File: rtl/snd_cen_pkg.sv
// snd_cen_pkg: default sizes and the clamped tap-shift helper for the cen divider
package snd_cen_pkg;
   localparam int CNTW_D  = 10;
   localparam int NTAP_D  = 4;
   localparam int FRACW_D = 16;
   localparam int SHW_D   = 4;
   // sel lowers the exponent by one; result is held inside 0..cntw
   function automatic logic [31:0] eff_shift(input logic [31:0] sh, input logic sel, input logic [31:0] cntw);
      logic [31:0] e;
      e = (sel && sh == 0) ? 32'd0 : sh - {31'd0, sel};
      return (e > cntw) ? cntw : e;
   endfunction
endpackage

// File: rtl/snd_cen_frac.sv
// snd_cen_frac: fractional num/den accumulator producing the base enable
module snd_cen_frac
   import snd_cen_pkg::*;
#(
   parameter int FRACW = FRACW_D
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cen_in,
   input  logic             sync,
   input  logic [FRACW-1:0] num,
   input  logic [FRACW-1:0] den,
   output logic             base,
   output logic             err
);
   logic [FRACW:0] sum;
   logic [FRACW-1:0] acc;
   logic dz, sat, hit;
   always_comb begin
      dz   = den == '0;
      sat  = ~dz & (num > den);
      sum  = {1'b0, acc} + {1'b0, num};
      hit  = sum >= {1'b0, den};
      err  = dz | (num > den);
      base = cen_in & ~sync & ~dz & (sat | hit);
   end
   // den==0 freezes acc; saturation keeps it at zero
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc <= '0;
      else if (sync | (cen_in & sat)) acc <= '0;
      else if (cen_in & ~dz) acc <= hit ? FRACW'(sum - {1'b0, den}) : FRACW'(sum);
endmodule

// File: rtl/snd_cen_div.sv
// snd_cen_div: base clock-enable (direct or fractional) divided into phase-aligned power-of-two taps
module snd_cen_div
   import snd_cen_pkg::*;
#(
   parameter int CNTW  = CNTW_D,
   parameter int NTAP  = NTAP_D,
   parameter int FRACW = FRACW_D,
   parameter int SHW   = SHW_D
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cen_in,
   input  logic                frac_en,
   input  logic [FRACW-1:0]    num,
   input  logic [FRACW-1:0]    den,
   input  logic                sel,
   input  logic [NTAP*SHW-1:0] shift,
   input  logic                sync,
   output logic                cen_base,
   output logic [NTAP-1:0]     cen_tap,
   output logic                cfg_err
);
   logic fbase, ferr, base;
   logic [CNTW-1:0] cnt;
   logic [NTAP-1:0] qual;
   snd_cen_frac #(.FRACW(FRACW)) u_frac (
      .clk(clk), .rst_n(rst_n), .cen_in(cen_in), .sync(sync),
      .num(num), .den(den), .base(fbase), .err(ferr)
   );
   assign base = frac_en ? fbase : cen_in & ~sync;
   genvar k;
   generate
      for (k = 0; k < NTAP; k++) begin : g_tap
         logic [31:0] e;
         // low e bits of the shared counter all zero -> tap fires; shifting by CNTW yields a full mask
         assign e       = eff_shift(32'(shift[k*SHW +: SHW]), sel, 32'(CNTW));
         assign qual[k] = base & ((cnt & ~({CNTW{1'b1}} << e)) == '0);
      end
   endgenerate
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt      <= '0;
         cen_base <= 1'b0;
         cen_tap  <= '0;
         cfg_err  <= 1'b0;
      end else begin
         cnt      <= sync ? '0 : base ? cnt + 1'b1 : cnt;
         cen_base <= base;
         cen_tap  <= qual;
         cfg_err  <= frac_en & ferr;
      end
endmodule

// File: tb/tb_snd_cen_div.sv
// tb_snd_cen_div: directed vector table plus multi-cycle sequences for snd_cen_div (CNTW=4 build)
module tb_snd_cen_div;
   localparam logic [15:0] SH = 16'h3210;
   typedef struct {
      logic cen, fr;
      logic [15:0] num, den;
      logic sel;
      logic [15:0] sh;
      logic sy, eb;
      logic [3:0] et;
      logic ee;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b0, cen_in = 1'b0, frac_en = 1'b0, sel = 1'b0, sync = 1'b0;
   logic [15:0] num = '0, den = '0, shift = '0;
   logic cen_base, cfg_err;
   logic [3:0] cen_tap;
   int n_chk = 0, n_fail = 0;
   vec_t tbl[$];
   snd_cen_div #(.CNTW(4), .NTAP(4), .FRACW(16), .SHW(4)) dut (
      .clk(clk), .rst_n(rst_n), .cen_in(cen_in), .frac_en(frac_en), .num(num), .den(den),
      .sel(sel), .shift(shift), .sync(sync), .cen_base(cen_base), .cen_tap(cen_tap), .cfg_err(cfg_err)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic add(input logic c, input logic f, input logic [15:0] n, input logic [15:0] d, input logic s,
                      input logic [15:0] h, input logic y, input logic b, input logic [3:0] t, input logic e);
      vec_t v;
      v = '{c, f, n, d, s, h, y, b, t, e};
      tbl.push_back(v);
   endtask
   task automatic sync_now;
      cen_in = 1'b0;
      sync = 1'b1;
      tick();
      sync = 1'b0;
   endtask
   task automatic run_taps(input string nm, input logic s, input logic [3:0] sh0, input int nb, input int per);
      int bad;
      bad = 0;
      sync_now();
      frac_en = 1'b0;
      sel = s;
      shift = {12'h0, sh0};
      cen_in = 1'b1;
      for (int n = 0; n < nb; n++) begin
         tick();
         if (cen_tap[0] !== ((n % per) == 0)) bad++;
         if (cen_base !== 1'b1) bad++;
      end
      cen_in = 1'b0;
      chk(nm, bad, 0);
   endtask
   initial begin
      logic [3:0] tap_exp [9];
      logic [7:0] pat;
      logic [2:0] post;
      int cnt, bad;
      tap_exp = '{4'b1111, 4'b0001, 4'b0011, 4'b0001, 4'b0111, 4'b0001, 4'b0011, 4'b0001, 4'b1111};
      for (int n = 0; n < 9; n++) begin
         add(1, 0, 0, 0, 0, SH, 0, 1, tap_exp[n], 0);
         add(0, 0, 0, 0, 0, SH, 0, 0, 4'b0000, 0);
      end
      add(1, 0, 0, 0, 0, SH, 1, 0, 4'b0000, 0);
      add(1, 0, 0, 0, 0, SH, 0, 1, 4'b1111, 0);
      add(1, 0, 0, 0, 0, SH, 0, 1, 4'b0001, 0);
      add(1, 1, 3, 0, 0, SH, 0, 0, 4'b0000, 1);
      add(1, 1, 9, 8, 0, SH, 0, 1, 4'b0011, 1);
      add(0, 1, 9, 8, 0, SH, 0, 0, 4'b0000, 1);
      add(1, 1, 9, 8, 0, SH, 0, 1, 4'b0001, 1);
      add(1, 1, 8, 8, 0, SH, 0, 1, 4'b0111, 0);
      add(1, 1, 3, 8, 0, SH, 0, 0, 4'b0000, 0);
      add(1, 1, 5, 8, 0, SH, 0, 1, 4'b0001, 0);
      #12;
      chk("reset_base", cen_base, 0);
      chk("reset_tap", cen_tap, 0);
      chk("reset_err", cfg_err, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      foreach (tbl[i]) begin
         cen_in = tbl[i].cen; frac_en = tbl[i].fr; num = tbl[i].num; den = tbl[i].den;
         sel = tbl[i].sel; shift = tbl[i].sh; sync = tbl[i].sy;
         tick();
         chk($sformatf("vec%0d_base", i), cen_base, tbl[i].eb);
         chk($sformatf("vec%0d_tap", i), cen_tap, tbl[i].et);
         chk($sformatf("vec%0d_err", i), cfg_err, tbl[i].ee);
      end
      // 3/8 accumulator: bases land on cycles 2, 5, 7 of every 8
      pat = 8'b1010_0100;
      sync_now();
      frac_en = 1'b1; num = 16'd3; den = 16'd8; sel = 1'b0; shift = '0; cen_in = 1'b1;
      cnt = 0; bad = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (cen_base) cnt++;
         if (cen_base !== pat[i % 8]) bad++;
      end
      chk("frac_count", cnt, 30);
      chk("frac_pattern", bad, 0);
      for (int i = 0; i < 4; i++) tick();
      sync = 1'b1;
      tick();
      chk("sync_cen_base", cen_base, 0);
      sync = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         post[i] = cen_base;
      end
      chk("sync_acc_restart", post, 3'b100);
      cen_in = 1'b0;
      run_taps("tap_sel1_sh4", 1'b1, 4'd4, 17, 8);
      run_taps("tap_sel0_sh4", 1'b0, 4'd4, 17, 16);
      run_taps("tap_sel1_sh0", 1'b1, 4'd0, 5, 1);
      run_taps("tap_clamp_sh15", 1'b0, 4'd15, 20, 16);
      run_taps("tap_wrap_40", 1'b0, 4'd4, 40, 16);
      frac_en = 1'b1; num = 16'd9; den = 16'd8; shift = SH; sel = 1'b0; cen_in = 1'b1;
      tick();
      chk("pre_rst_base", cen_base, 1);
      chk("pre_rst_err", cfg_err, 1);
      cen_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_base", cen_base, 0);
      chk("async_rst_tap", cen_tap, 0);
      chk("async_rst_err", cfg_err, 0);
      tick();
      rst_n = 1'b1;
      frac_en = 1'b0; cen_in = 1'b1;
      tick();
      chk("post_rst_base", cen_base, 1);
      chk("post_rst_tap", cen_tap, 4'b1111);
      cen_in = 1'b0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
